y_arith_serial: RTL and testbench



---
 rtl/y_arith_pkg.sv | 28 ++
 rtl/y_digit_add.sv | 35 +++
 rtl/y_arith_serial.sv | 180 ++++++++++++++++++
 tb/tb_y_arith_serial.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_arith_pkg.sv
// ---------------------------------------------------------------------------
// y_arith_pkg
// Shared encodings for the digit-serial add/subtract unit.
//   op_e    : operation codes carried on the 2-bit 'op' port
//   state_e : sequencer states (idle, digit loop, result held)
//   op_is_sub() : true for the two operations that invert operand b
// ---------------------------------------------------------------------------
package y_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Subtraction is done as a + ~b + carry, so both subtract flavours invert b.
  function automatic logic op_is_sub(input op_e o);
    return (o == OP_SUB) || (o == OP_SBC);
  endfunction

endpackage

// File: rtl/y_digit_add.sv
// ---------------------------------------------------------------------------
// y_digit_add
// Combinational DIGIT-bit ripple-carry adder used once per clock by the
// serial unit to process one digit of the operands.
//   a, b : DIGIT-bit addends
//   cin  : carry into bit 0
//   s    : DIGIT-bit sum
//   cout : carry out of the top bit
// ---------------------------------------------------------------------------
module y_digit_add #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] carry;

  // Explicit bit-by-bit ripple; one full adder per bit.
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[DIGIT];

endmodule

// File: rtl/y_arith_serial.sv
// ---------------------------------------------------------------------------
// y_arith_serial
// Digit-serial add/subtract unit with carry-chained modes for multi-precision
// arithmetic. One operation takes WIDTH/DIGIT clocks in the digit loop; the
// result and C/V/N/Z flags are registered and held until the consumer takes
// them. An internal carry flag links consecutive ADC/SBC operations.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operation handshake (a, b, op sampled on accept)
//   out_valid/out_ready : result handshake
//   z                   : WIDTH-bit result
//   cout                : carry out (for subtracts, 1 = no borrow)
//   ovf, neg, zero      : signed overflow, result sign, result is zero
// ---------------------------------------------------------------------------
module y_arith_serial
  import y_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             neg,
  output logic             zero
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("y_arith_serial: DIGIT (%0d) must divide WIDTH (%0d) exactly", DIGIT, WIDTH);
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   z_q, z_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               neg_q, neg_d;
  logic               zero_q, zero_d;
  logic               cflag_q, cflag_d;

  logic [DIGIT-1:0]   dig_s;
  logic               dig_cout;
  logic [WIDTH-1:0]   res_next;
  op_e                op_sel;

  y_digit_add #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh_q[DIGIT-1:0]),
    .b    (b_sh_q[DIGIT-1:0]),
    .cin  (c_q),
    .s    (dig_s),
    .cout (dig_cout)
  );

  // New digit enters at the top so that after NDIG steps the first digit has
  // reached bit 0. Written as shifts so DIGIT==WIDTH needs no special case.
  assign res_next = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
  assign op_sel   = op_e'(op);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    z_d     = z_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    cflag_d = cflag_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = op_is_sub(op_sel) ? ~b : b;
          case (op_sel)
            OP_ADD:  c_d = 1'b0;
            OP_SUB:  c_d = 1'b1;
            default: c_d = cflag_q;
          endcase
          a_msb_d = a[WIDTH-1];
          b_msb_d = b_sh_d[WIDTH-1];
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        res_d  = res_next;
        c_d    = dig_cout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          // Overflow: like-signed operands producing a result of the other sign.
          z_d     = res_next;
          cout_d  = dig_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
          neg_d   = res_next[WIDTH-1];
          zero_d  = (res_next == '0);
          cflag_d = dig_cout;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      cflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      cflag_q <= cflag_d;
    end
  end

  // in_ready is gated by rst_n so it is low for the whole time reset is held.
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign z         = z_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign neg       = neg_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_y_arith_serial.sv
// ---------------------------------------------------------------------------
// tb_y_arith_serial
// Self-checking bench for y_arith_serial: a WIDTH=32/DIGIT=8 instance carries
// the directed sequence, a DIGIT=32 instance checks the single-digit build.
// Expected results are queued when an operation is issued and compared when
// the unit presents its result.
// ---------------------------------------------------------------------------
module tb_y_arith_serial;

  localparam int W = 32;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ADC = 2'b10;
  localparam logic [1:0] SBC = 2'b11;

  typedef struct packed {
    logic [W-1:0] z;
    logic         cout;
    logic         ovf;
    logic         neg;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, z;
  logic [1:0]   op;
  logic         cout, ovf, neg, zero;

  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [W-1:0] a2, b2, z2;
  logic [1:0]   op2;
  logic         cout2, ovf2, neg2, zero2;

  y_arith_serial #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .cout(cout), .ovf(ovf), .neg(neg), .zero(zero)
  );

  y_arith_serial #(.WIDTH(32), .DIGIT(32)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2),
    .z(z2), .cout(cout2), .ovf(ovf2), .neg(neg2), .zero(zero2)
  );

  exp_t sb_q[$];
  exp_t sb2_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic model_cflag = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop so a hung handshake can never stall the run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input logic [W-1:0] zz, input logic c, input logic v,
                              input logic n, input logic zr);
    exp_t e;
    e.z = zz; e.cout = c; e.ovf = v; e.neg = n; e.zero = zr;
    return e;
  endfunction

  // Reference model: unsigned sum for z/cout, true signed arithmetic for ovf.
  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic [1:0] opi, input logic cf);
    exp_t        e;
    logic [W-1:0] bx;
    logic        ci;
    logic [W:0]  sum;
    longint      sa, sbv, full;
    bx = bi; ci = 1'b0;
    case (opi)
      ADD:     begin bx = bi;  ci = 1'b0; end
      SUB:     begin bx = ~bi; ci = 1'b1; end
      ADC:     begin bx = bi;  ci = cf;   end
      default: begin bx = ~bi; ci = cf;   end
    endcase
    sum = {1'b0, ai} + {1'b0, bx} + {{W{1'b0}}, ci};
    sa  = longint'($signed(ai));
    sbv = longint'($signed(bi));
    if (opi == SUB || opi == SBC) full = sa - sbv - (ci ? 64'sd0 : 64'sd1);
    else                          full = sa + sbv + (ci ? 64'sd1 : 64'sd0);
    e.z    = sum[W-1:0];
    e.cout = sum[W];
    e.ovf  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    e.neg  = sum[W-1];
    e.zero = (sum[W-1:0] == '0);
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, issues one operation, optionally queues its result.
  task automatic applyStimulus(input logic [W-1:0] ai, input logic [W-1:0] bi,
                               input logic [1:0] opi, input exp_t e, input bit expect_result);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("accept_ready", 64'(in_ready), 64'(1));
    a = ai; b = bi; op = opi; in_valid = 1'b1;
    if (expect_result) begin
      sb_q.push_back(e);
      model_cflag = e.cout;
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  task automatic waitForOutput(input string tag, input int exp_lat);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_latency"}, 64'(cyc - accept_cyc), 64'(exp_lat));
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s_queue: observed empty scoreboard expected an entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val({tag, "_valid"}, 64'(out_valid), 64'(1));
      check_val({tag, "_z"},     64'(z),    64'(e.z));
      check_val({tag, "_cout"},  64'(cout), 64'(e.cout));
      check_val({tag, "_ovf"},   64'(ovf),  64'(e.ovf));
      check_val({tag, "_neg"},   64'(neg),  64'(e.neg));
      check_val({tag, "_zero"},  64'(zero), 64'(e.zero));
    end
  endtask

  task automatic releaseOutput(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_rel_ready"}, 64'(in_ready),  64'(1));
    check_val({tag, "_rel_valid"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    exp_t        hold, e2;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    bit           saw_valid;
    int           first_acc, n;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = ADD;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; op2 = ADD;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_in_ready",  64'(in_ready),  64'(0));
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_flags",     64'({z, cout, ovf, neg, zero}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_in_ready", 64'(in_ready), 64'(1));

    // Signed overflow into the sign bit, latency NDIG=4
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, ADD, mk(32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0), 1);
    waitForOutput("add_ovf", 4);
    checkOutput("add_ovf");
    releaseOutput("add_ovf");

    applyStimulus(32'd5, 32'd7, SUB, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    waitForOutput("sub_neg", 4);
    checkOutput("sub_neg");
    releaseOutput("sub_neg");

    applyStimulus(32'd7, 32'd5, SUB, mk(32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0), 1);
    waitForOutput("sub_pos", 4);
    checkOutput("sub_pos");
    releaseOutput("sub_pos");

    // 64-bit chain through the internal carry flag
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, ADD, mk(32'h0, 1'b1, 1'b0, 1'b0, 1'b1), 1);
    waitForOutput("chain_add", 4);
    checkOutput("chain_add");
    releaseOutput("chain_add");

    applyStimulus(32'h0, 32'h0, ADC, mk(32'h1, 1'b0, 1'b0, 1'b0, 1'b0), 1);
    waitForOutput("chain_adc", 4);
    checkOutput("chain_adc");
    releaseOutput("chain_adc");

    applyStimulus(32'h0, 32'h0, SBC, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    waitForOutput("chain_sbc", 4);
    checkOutput("chain_sbc");
    releaseOutput("chain_sbc");

    // Backpressure: result held five cycles with a stray in_valid pulse
    applyStimulus(32'h1234_5678, 32'h1111_1111, ADD, mk(32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0), 1);
    waitForOutput("bp", 4);
    hold = sb_q[0];
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = SUB;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check_val("bp_hold_valid", 64'(out_valid), 64'(1));
      check_val("bp_hold_ready", 64'(in_ready),  64'(0));
      check_val("bp_hold_data",  64'({z, cout, ovf, neg, zero}), 64'(hold));
    end
    in_valid = 1'b0;
    checkOutput("bp");
    releaseOutput("bp");

    // Leave non-zero outputs and cflag=1 before the mid-run reset
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, ADD, mk(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0), 1);
    waitForOutput("pre_rst", 4);
    checkOutput("pre_rst");
    releaseOutput("pre_rst");

    // Reset during the second digit cycle discards the operation
    applyStimulus(32'd1, 32'd1, ADD, mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check_val("mid_rst_ready_low", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_cflag = 1'b0;
    @(negedge clk);
    check_val("mid_rst_valid",  64'(out_valid), 64'(0));
    check_val("mid_rst_flags",  64'({z, cout, ovf, neg, zero}), 64'(0));
    check_val("mid_rst_ready",  64'(in_ready),  64'(1));
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check_val("mid_rst_no_valid", 64'(saw_valid), 64'(0));

    // cflag must have been cleared: 3+4+0
    applyStimulus(32'd3, 32'd4, ADC, mk(32'd7, 1'b0, 1'b0, 1'b0, 1'b0), 1);
    waitForOutput("post_rst_adc", 4);
    checkOutput("post_rst_adc");
    releaseOutput("post_rst_adc");

    // Random operations against the reference model
    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = (i == 3) ? ra : $urandom;
      rop = 2'($urandom);
      applyStimulus(ra, rb, rop, model(ra, rb, rop, model_cflag), 1);
      waitForOutput("rand", 4);
      checkOutput("rand");
      releaseOutput("rand");
    end

    // Single-digit build: one RUN cycle, issue period NDIG+2 = 3
    @(negedge clk);
    check_val("wide_ready", 64'(in_ready2), 64'(1));
    a2 = 32'd1; b2 = 32'd2; op2 = ADD; in_valid2 = 1'b1;
    sb2_q.push_back(mk(32'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    first_acc = cyc;
    in_valid2 = 1'b0;
    @(negedge clk);
    check_val("wide_busy", 64'(in_ready2), 64'(0));
    @(negedge clk);
    check_val("wide_latency", 64'(out_valid2), 64'(1));
    e2 = sb2_q.pop_front();
    check_val("wide_add", 64'({z2, cout2, ovf2, neg2, zero2}), 64'(e2));
    out_ready2 = 1'b1;
    @(posedge clk);
    #1;
    out_ready2 = 1'b0;
    @(negedge clk);
    check_val("wide_ready_again", 64'(in_ready2), 64'(1));
    a2 = 32'd10; b2 = 32'd3; op2 = SUB; in_valid2 = 1'b1;
    sb2_q.push_back(mk(32'd7, 1'b1, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check_val("wide_issue_period", 64'(cyc - first_acc), 64'(3));
    in_valid2 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("wide_sub_valid", 64'(out_valid2), 64'(1));
    e2 = sb2_q.pop_front();
    check_val("wide_sub", 64'({z2, cout2, ovf2, neg2, zero2}), 64'(e2));
    out_ready2 = 1'b1;
    @(posedge clk);
    #1;
    out_ready2 = 1'b0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
